// File: rtl/inc_display_pkg.sv
// Shared types, segment encodings and a BCD digit helper
// for the increment-pulse BCD display.
package inc_display_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic       c;
    bcd_digit_t d;
  } bcd_inc_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic bcd_inc_t bcd_inc(
    input bcd_digit_t d,
    input logic       cin
  );
    bcd_inc_t r;
    r.c = 1'b0;
    r.d = d;
    if (cin) begin
      if (d >= 4'd9) begin
        r.c = 1'b1;
        r.d = 4'd0;
      end else begin
        r.d = d + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low segment decoder;
// non-decimal codes blank the digit.
module bcd_to_7seg
  import inc_display_pkg::*;
(
  input  bcd_digit_t digit_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/inc_pulse_bcd_display.sv
// Packed-BCD pulse counter driving a multiplexed
// common-anode seven-segment display.
module inc_pulse_bcd_display
  import inc_display_pkg::*;
#(
  parameter int unsigned N_DIGITS           = 4,
  parameter int unsigned REFRESH_DIV        = 100000,
  parameter bit          LEADING_ZERO_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_pulse,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic                  overflow_pulse,
  output logic [N_DIGITS-1:0]   an,
  output seg_t                  seg,
  output logic                  dp
);

  localparam int unsigned REF_W =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SEL_W =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [REF_W-1:0] REF_MAX =
    REF_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_MAX =
    SEL_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] count_q, count_d;
  logic [4*N_DIGITS-1:0] inc_val;
  logic                  ovf_q, ovf_d;
  logic                  wrap;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  seg_t                  seg_q, seg_d;
  seg_t                  dec_seg;
  bcd_digit_t            cur_digit;
  logic                  blank;
  logic                  carry;
  logic                  zero_up;
  bcd_inc_t              dig_r;

  // Ripple the +1 through every digit
  always_comb begin
    carry   = 1'b1;
    inc_val = '0;
    dig_r   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      dig_r = bcd_inc(count_q[i*4 +: 4], carry);
      inc_val[i*4 +: 4] = dig_r.d;
      carry = dig_r.c;
    end
    wrap = carry;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (inc_pulse) begin
      count_d = inc_val;
      ovf_d   = wrap;
    end
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    sel_d = sel_q;
    if (ref_q == REF_MAX) begin
      ref_d = '0;
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end
  end

  // Digit k>0 goes dark when it and all digits above are zero
  always_comb begin
    cur_digit = '0;
    blank     = 1'b0;
    zero_up   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_up = zero_up & (count_q[i*4 +: 4] == 4'd0);
      if (sel_q == SEL_W'(i)) begin
        cur_digit = count_q[i*4 +: 4];
        blank = LEADING_ZERO_BLANK && (i > 0) && zero_up;
      end
    end
  end

  bcd_to_7seg u_dec (
    .digit_i (cur_digit),
    .seg_o   (dec_seg)
  );

  always_comb begin
    an_d  = ~(N_DIGITS'(1) << sel_q);
    seg_d = dec_seg;
    if (blank) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      sel_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd      = count_q;
  assign overflow_pulse = ovf_q;
  assign an             = an_q;
  assign seg            = seg_q;
  assign dp             = 1'b1;

endmodule

// File: tb/tb_inc_pulse_bcd_display.sv
// Scoreboard bench: stimulus queues per-cycle expectations,
// a monitor pops and compares after each clock edge.
module tb_inc_pulse_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc_pulse = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] count_bcd;
  logic        overflow_pulse;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  inc_pulse_bcd_display #(
    .N_DIGITS           (4),
    .REFRESH_DIV        (4),
    .LEADING_ZERO_BLANK (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inc_pulse      (inc_pulse),
    .clear          (clear),
    .count_bcd      (count_bcd),
    .overflow_pulse (overflow_pulse),
    .an             (an),
    .seg            (seg),
    .dp             (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    string       name;
    int          sel;
    logic [15:0] exp;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    last_tag;
  bit    done = 1'b0;

  int mval = 0;
  int mr = 0;
  int ms = 0;

  logic [6:0] segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  task automatic push(input int tag, input string nm,
                      input int sel, input logic [15:0] e);
    item_t it;
    it.tag = tag;
    it.name = nm;
    it.sel = sel;
    it.exp = e;
    q.push_back(it);
  endtask

  task automatic step(input logic r, input logic inc,
                      input logic clr);
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       eovf;
    int         dv;
    @(negedge clk);
    rst = r;
    inc_pulse = inc;
    clear = clr;
    last_tag = cyc + 1;
    eovf = 1'b0;
    if (r) begin
      ean = 4'hF;
      eseg = 7'h7F;
      mval = 0;
      mr = 0;
      ms = 0;
    end else begin
      dv = (mval / pow10(ms)) % 10;
      if (ms > 0 && mval < pow10(ms)) begin
        ean = 4'hF;
        eseg = 7'h7F;
      end else begin
        ean = ~(4'b0001 << ms);
        eseg = segtab[dv];
      end
      if (clr) begin
        mval = 0;
      end else if (inc) begin
        mval = (mval + 1) % 10000;
        eovf = (mval == 0);
      end
      if (mr == 3) begin
        mr = 0;
        ms = (ms + 1) % 4;
      end else begin
        mr = mr + 1;
      end
    end
    push(last_tag, "count", 0, to_bcd(mval));
    push(last_tag, "ovf", 1, {15'd0, eovf});
    push(last_tag, "an", 2, {12'd0, ean});
    push(last_tag, "seg", 3, {9'd0, eseg});
  endtask

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      0: return count_bcd;
      1: return {15'd0, overflow_pulse};
      2: return {12'd0, an};
      default: return {9'd0, seg};
    endcase
  endfunction

  initial begin
    item_t it;
    logic [15:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= 1) begin
        checks++;
        if (dp !== 1'b1) begin
          errors++;
          $display("FAIL dp cyc=%0d got=%b want=1", cyc, dp);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
          a = count_bcd;
          if (a[k*4 +: 4] > 4'd9 || $isunknown(a)) begin
            errors++;
            $display("FAIL nibble cyc=%0d got=%h want=bcd",
                     cyc, count_bcd);
            break;
          end
        end
      end
      while (q.size() > 0 && q[0].tag <= cyc) begin
        it = q.pop_front();
        a = actual(it.sel);
        checks++;
        if (it.tag != cyc || a !== it.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d tag=%0d got=%h want=%h",
                   it.name, cyc, it.tag, a, it.exp);
        end
      end
    end
  end

  initial begin
    // 1: reset then release
    repeat (3) step(1'b1, 1'b0, 1'b0);
    push(last_tag, "rst_an", 2, 16'h000F);
    push(last_tag, "rst_seg", 3, 16'h007F);
    step(1'b0, 1'b0, 1'b0);
    push(last_tag, "rel_an", 2, 16'h000E);
    push(last_tag, "rel_seg", 3, 16'h0040);

    // 2: ten isolated pulses
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 9) push(last_tag, "cnt9", 0, 16'h0009);
      if (i == 10) push(last_tag, "cnt10", 0, 16'h0010);
      step(1'b0, 1'b0, 1'b0);
    end

    // 3: 9999 back-to-back pulses, then wrap
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9999; i++) step(1'b0, 1'b1, 1'b0);
    push(last_tag, "cnt9999", 0, 16'h9999);
    step(1'b0, 1'b1, 1'b0);
    push(last_tag, "wrap_cnt", 0, 16'h0000);
    push(last_tag, "wrap_ovf", 1, 16'h0001);
    step(1'b0, 1'b0, 1'b0);
    push(last_tag, "ovf_drop", 1, 16'h0000);

    // 4: clear beats inc
    for (int i = 0; i < 42; i++) step(1'b0, 1'b1, 1'b0);
    push(last_tag, "cnt42", 0, 16'h0042);
    step(1'b0, 1'b1, 1'b1);
    push(last_tag, "clr_cnt", 0, 16'h0000);
    push(last_tag, "clr_ovf", 1, 16'h0000);

    // 5: scan of 0123 with dark leading slot
    for (int i = 0; i < 123; i++) step(1'b0, 1'b1, 1'b0);
    push(last_tag, "cnt123", 0, 16'h0123);
    repeat (16) step(1'b0, 1'b0, 1'b0);

    // 6: reset mid-slot with inc high
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0);
    push(last_tag, "cnt500", 0, 16'h0500);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    push(last_tag, "rst6_cnt", 0, 16'h0000);
    push(last_tag, "rst6_an", 2, 16'h000F);
    step(1'b0, 1'b0, 1'b0);
    push(last_tag, "rst6_scan", 2, 16'h000E);
    repeat (8) step(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
